booth_r4_mult: RTL and testbench

Parametrised, sequential radix-4 Booth multiplier. It replaces the fixed 8-bit `booth_top` in the arithmetic datapath with a configurable operand width and a per-operation signed/unsigned mode. A valid/ready handshake sits on both the operand and result sides. It computes one radix-4 digit per cycle and holds the product until the downstream consumer accepts it.

---
 rtl/booth_r4_mult.sv | 137 +++++++++++++
 tb/tb_booth_r4_mult.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/booth_r4_mult.sv
// Sequential radix-4 Booth multiplier, WIDTH x WIDTH -> 2*WIDTH, signed or unsigned per operation.
// Latency: accept at edge k -> out_valid after edge k+N (N = WIDTH/2+1); one op per N+2 cycles.
// Backpressure: result/out_valid held in DONE until out_ready; in_ready low outside IDLE.
//
// Ports:
//   clk, rst                : rising-edge clock, synchronous active-high reset
//   in_valid / in_ready     : operand handshake (mult_a, mult_b, signed_mode sampled on accept)
//   out_valid / out_ready   : result handshake (result holds the product, retained afterwards)
//   busy                    : high while an operation is in CALC or DONE
module booth_r4_mult #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   mult_a,
  input  logic [WIDTH-1:0]   mult_b,
  input  logic               signed_mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] result,
  output logic               busy
);

  localparam int WE = WIDTH + 2;      // extended operand width
  localparam int N  = WE / 2;         // Booth digits per operation
  localparam int AW = 2 * WE;         // accumulator width
  localparam int CW = $clog2(N) + 1;  // digit counter width

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [AW-1:0]      mcand_q, mcand_d;    // A << 2i, pre-extended to accumulator width
  logic [WE:0]        mplier_q, mplier_d;  // {b, b[-1]}, shifted right two bits per digit
  logic [AW-1:0]      acc_q, acc_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] result_q, result_d;
  logic               out_valid_q, out_valid_d;

  logic          ext_sa, ext_sb;
  logic [AW-1:0] ext_a;
  logic [WE-1:0] ext_b;
  logic [AW-1:0] pp;
  logic [AW-1:0] acc_sum;

  // Extension bit is the operand sign in signed mode and zero otherwise; this
  // one choice makes the same recoding exact for both modes.
  assign ext_sa = signed_mode & mult_a[WIDTH-1];
  assign ext_sb = signed_mode & mult_b[WIDTH-1];
  assign ext_a  = {{(AW-WIDTH){ext_sa}}, mult_a};
  assign ext_b  = {{(WE-WIDTH){ext_sb}}, mult_b};

  // Partial product from the current 3-bit window {b[2i+1], b[2i], b[2i-1]}.
  always_comb begin
    pp = '0;
    unique case (mplier_q[2:0])
      3'b001, 3'b010: pp = mcand_q;
      3'b011:         pp = {mcand_q[AW-2:0], 1'b0};
      3'b100:         pp = -{mcand_q[AW-2:0], 1'b0};
      3'b101, 3'b110: pp = -mcand_q;
      default:        pp = '0;
    endcase
  end

  assign acc_sum = acc_q + pp;

  always_comb begin
    state_d     = state_q;
    mcand_d     = mcand_q;
    mplier_d    = mplier_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    result_d    = result_q;
    out_valid_d = out_valid_q;
    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          mcand_d  = ext_a;
          mplier_d = {ext_b, 1'b0};
          acc_d    = '0;
          cnt_d    = '0;
          state_d  = S_CALC;
        end
      end
      S_CALC: begin
        acc_d    = acc_sum;
        // Arithmetic shift keeps the sign for the final digit window.
        mplier_d = {{2{mplier_q[WE]}}, mplier_q[WE:2]};
        mcand_d  = {mcand_q[AW-3:0], 2'b00};
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == CW'(N-1)) begin
          state_d     = S_DONE;
          result_d    = acc_sum[2*WIDTH-1:0];
          out_valid_d = 1'b1;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d     = S_IDLE;
          out_valid_d = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      mcand_q     <= '0;
      mplier_q    <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      result_q    <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      result_q    <= result_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign busy      = (state_q == S_CALC) || (state_q == S_DONE);
  assign out_valid = out_valid_q;
  assign result    = result_q;

endmodule

// File: tb/tb_booth_r4_mult.sv
// Testbench for booth_r4_mult at WIDTH=8 and WIDTH=16.
// Expected products are queued on accept and compared on the output handshake.
// Inputs are driven 1 time unit after the rising edge; outputs are sampled on the falling edge.
module tb_booth_r4_mult;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  // W=8 instance
  logic        in_valid8 = 1'b0, sm8 = 1'b0, out_ready8 = 1'b1;
  logic [7:0]  mult_a8 = '0, mult_b8 = '0;
  logic        in_ready8, out_valid8, busy8;
  logic [15:0] result8;

  // W=16 instance
  logic        in_valid16 = 1'b0, sm16 = 1'b0, out_ready16 = 1'b1;
  logic [15:0] mult_a16 = '0, mult_b16 = '0;
  logic        in_ready16, out_valid16, busy16;
  logic [31:0] result16;

  booth_r4_mult #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
    .mult_a(mult_a8), .mult_b(mult_b8), .signed_mode(sm8),
    .out_valid(out_valid8), .out_ready(out_ready8), .result(result8), .busy(busy8)
  );

  booth_r4_mult #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .in_valid(in_valid16), .in_ready(in_ready16),
    .mult_a(mult_a16), .mult_b(mult_b16), .signed_mode(sm16),
    .out_valid(out_valid16), .out_ready(out_ready16), .result(result16), .busy(busy16)
  );

  logic [15:0] exp8_q[$];
  int          cyc8_q[$];
  logic [31:0] exp16_q[$];
  int          cyc16_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Output monitors: latency on the rising edge of out_valid, value on the handshake.
  logic ov8_prev = 1'b0;
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid8 && !ov8_prev) begin
        if (cyc8_q.size() == 0) check("w8_spurious_out_valid", 64'(out_valid8), 64'd0);
        else check("w8_latency", 64'(cyc - cyc8_q[0]), 64'd5);
      end
      if (out_valid8 && out_ready8 && exp8_q.size() != 0) begin
        check("w8_result", 64'(result8), 64'(exp8_q.pop_front()));
        void'(cyc8_q.pop_front());
      end
    end
    ov8_prev = out_valid8;
  end

  logic ov16_prev = 1'b0;
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid16 && !ov16_prev) begin
        if (cyc16_q.size() == 0) check("w16_spurious_out_valid", 64'(out_valid16), 64'd0);
        else check("w16_latency", 64'(cyc - cyc16_q[0]), 64'd9);
      end
      if (out_valid16 && out_ready16 && exp16_q.size() != 0) begin
        check("w16_result", 64'(result16), 64'(exp16_q.pop_front()));
        void'(cyc16_q.pop_front());
      end
    end
    ov16_prev = out_valid16;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv8(input logic [7:0] a, input logic [7:0] b, input logic sm,
                      input logic [15:0] exp);
    int n = 0;
    while (!in_ready8 && n < 200) begin tick(); n++; end
    check("w8_in_ready_before_accept", 64'(in_ready8), 64'd1);
    in_valid8 = 1'b1; mult_a8 = a; mult_b8 = b; sm8 = sm;
    tick();
    exp8_q.push_back(exp);
    cyc8_q.push_back(cyc);
    // Operands and mode are scrambled after accept; they must not matter.
    in_valid8 = 1'b0; mult_a8 = 8'($urandom); mult_b8 = 8'($urandom); sm8 = ~sm;
  endtask

  task automatic drv16(input logic [15:0] a, input logic [15:0] b, input logic sm);
    longint sa, sb, prod;
    int n = 0;
    sa = sm ? longint'($signed(a)) : longint'(a);
    sb = sm ? longint'($signed(b)) : longint'(b);
    prod = sa * sb;
    while (!in_ready16 && n < 200) begin tick(); n++; end
    if (!in_ready16) check("w16_in_ready_timeout", 64'(in_ready16), 64'd1);
    in_valid16 = 1'b1; mult_a16 = a; mult_b16 = b; sm16 = sm;
    tick();
    exp16_q.push_back(prod[31:0]);
    cyc16_q.push_back(cyc);
    in_valid16 = 1'b0; mult_a16 = 16'($urandom); mult_b16 = 16'($urandom); sm16 = ~sm;
  endtask

  task automatic drain();
    int n = 0;
    while ((exp8_q.size() != 0 || exp16_q.size() != 0) && n < 200) begin tick(); n++; end
    check("drain_w8_queue_empty", 64'(exp8_q.size()), 64'd0);
    check("drain_w16_queue_empty", 64'(exp16_q.size()), 64'd0);
    tick();
  endtask

  initial begin
    rst = 1'b1;
    repeat (3) tick();
    check("rst_w8_in_ready", 64'(in_ready8), 64'd1);
    check("rst_w8_out_valid", 64'(out_valid8), 64'd0);
    check("rst_w8_busy", 64'(busy8), 64'd0);
    check("rst_w8_result", 64'(result8), 64'd0);
    check("rst_w16_out_valid", 64'(out_valid16), 64'd0);
    check("rst_w16_result", 64'(result16), 64'd0);
    rst = 1'b0;
    tick();
    check("post_rst_w8_in_ready", 64'(in_ready8), 64'd1);

    // Signed W=8 sequence (21*54 = 1134 = 0x046E)
    drv8(8'hF9, 8'hFD, 1'b1, 16'h0015);
    drv8(8'd21, 8'd54, 1'b1, 16'h046E);
    drv8(8'hDD, 8'd42, 1'b1, 16'hFA42);
    drv8(8'h80, 8'd42, 1'b1, 16'hEB00);
    drv8(8'h80, 8'd64, 1'b1, 16'hE000);
    // Signed corners
    drv8(8'h80, 8'h80, 1'b1, 16'h4000);
    drv8(8'h7F, 8'h80, 1'b1, 16'hC080);
    drv8(8'h00, 8'hFF, 1'b1, 16'h0000);
    // Unsigned vs signed on identical bit patterns
    drv8(8'hFF, 8'hFF, 1'b0, 16'hFE01);
    drv8(8'h80, 8'h02, 1'b0, 16'h0100);
    drv8(8'hFF, 8'hFF, 1'b1, 16'h0001);
    drv8(8'h80, 8'h02, 1'b1, 16'hFF00);
    drain();

    // Back-pressure: 100 * -3 = -300
    out_ready8 = 1'b0;
    drv8(8'd100, 8'hFD, 1'b1, 16'hFED4);
    begin
      int n = 0;
      while (!out_valid8 && n < 50) begin tick(); n++; end
    end
    // Simultaneous in_valid during DONE must not be accepted.
    in_valid8 = 1'b1; mult_a8 = 8'd1; mult_b8 = 8'd1;
    for (int i = 0; i < 10; i++) begin
      check("bp_out_valid", 64'(out_valid8), 64'd1);
      check("bp_result", 64'(result8), 64'hFED4);
      check("bp_in_ready", 64'(in_ready8), 64'd0);
      tick();
    end
    out_ready8 = 1'b1;
    tick();
    in_valid8 = 1'b0;
    check("bp_in_ready_after_handshake", 64'(in_ready8), 64'd1);
    check("bp_out_valid_after_handshake", 64'(out_valid8), 64'd0);
    check("bp_result_retained", 64'(result8), 64'hFED4);
    tick();
    check("bp_no_accept_in_done", 64'(busy8), 64'd0);

    // Reset two cycles after accept discards the operation.
    in_valid8 = 1'b1; mult_a8 = 8'd9; mult_b8 = 8'd9; sm8 = 1'b0;
    tick();
    in_valid8 = 1'b0;
    check("rmid_busy_in_calc", 64'(busy8), 64'd1);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rmid_in_ready", 64'(in_ready8), 64'd1);
    check("rmid_busy", 64'(busy8), 64'd0);
    check("rmid_out_valid", 64'(out_valid8), 64'd0);
    check("rmid_result", 64'(result8), 64'd0);
    repeat (8) tick();
    check("rmid_no_out_valid", 64'(out_valid8), 64'd0);
    drv8(8'd3, 8'd4, 1'b1, 16'h000C);
    drain();

    // W=16 corners and random
    drv16(16'h8000, 16'h8000, 1'b1);
    drv16(16'hFFFF, 16'hFFFF, 1'b0);
    drv16(16'hFFFF, 16'hFFFF, 1'b1);
    drv16(16'h7FFF, 16'h8000, 1'b1);
    for (int i = 0; i < 1000; i++) begin
      drv16(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)));
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete (cycle %0d)", cyc);
    $fatal(1, "timeout");
  end

endmodule
